mult_arbiter: RTL and testbench

//  Shares one pipelined 32x32 multiplier between NUM_REQ requesters.
//  - Round-robin arbiter accepts at most one operand pair per cycle.
//  - Each accepted request enters a LAT-stage multiplier pipeline.
//  - Products return in issue order through an RSP_DEPTH result FIFO, tagged with the requester id.
//  - Sits between the multiply clients and the multiplier datapath.

---
 rtl/mult_arb_pkg.sv | 28 ++
 rtl/mult_arb_pipe.sv | 65 ++++++
 rtl/mult_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Optional feature macro: MULT_ARB_SIGNED_EN (per-request signed multiply).
package mult_arb_pkg;

   localparam int DATA_W   = 32;
   localparam int PROD_W   = 64;
   // Widest requester id carried in the operand bundle (NUM_REQ <= 8)
   localparam int ID_MAX_W = 3;

   // Bits needed to name one of n requesters (at least one bit)
   function automatic int id_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

   // One operand pair as it travels through the multiplier pipeline
   typedef struct packed {
      logic [DATA_W-1:0]   a;
      logic [DATA_W-1:0]   b;
      logic [ID_MAX_W-1:0] id;
      logic                signed_flag;
   } mult_op_t;

endpackage

// File: rtl/mult_arb_pipe.sv
// LAT-stage multiplier pipeline. Operands, id and signed flag shift down the
// stages; the product is formed from the tail stage. Only valids are reset.
// The signed flag is honoured whenever set; the top level ties it low unless
// MULT_ARB_SIGNED_EN is defined.
module mult_pipe
   import mult_arb_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  mult_op_t            in_op,
   output logic                out_valid,
   output logic [PROD_W-1:0]   out_prod,
   output logic [ID_MAX_W-1:0] out_id,
   output logic                busy
);

   logic [LAT-1:0]    vld_q;
   logic [LAT-1:0]    vld_d;
   mult_op_t          op_q [LAT];
   mult_op_t          op_d [LAT];
   logic [PROD_W-1:0] ext_a_s;
   logic [PROD_W-1:0] ext_b_s;

   // Advance valid bits and operand bundles by one stage
   always_comb begin
      vld_d    = vld_q;
      op_d     = op_q;
      vld_d[0] = in_valid;
      op_d[0]  = in_op;
      for (int k = 1; k < LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         op_d[k]  = op_q[k-1];
      end
   end

   // Stage valid registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Stage payload registers, never reset (qualified by the valids)
   always_ff @(posedge clk) begin
      op_q <= op_d;
   end

   // Tail multiply: sign-extend to 64 bits only when the signed flag is set,
   // so a 64x64 truncated product is the correct signed or unsigned result
   always_comb begin
      ext_a_s  = {{DATA_W{op_q[LAT-1].signed_flag & op_q[LAT-1].a[DATA_W-1]}}, op_q[LAT-1].a};
      ext_b_s  = {{DATA_W{op_q[LAT-1].signed_flag & op_q[LAT-1].b[DATA_W-1]}}, op_q[LAT-1].b};
      out_prod = ext_a_s * ext_b_s;
   end

   assign out_valid = vld_q[LAT-1];
   assign out_id    = op_q[LAT-1].id;
   assign busy      = |vld_q;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined 32x32 multiplier between NUM_REQ requesters:
// round-robin arbiter, credit counter capping outstanding work at RSP_DEPTH,
// and an in-order result FIFO tagged with the requester id.
// Optional feature macro: MULT_ARB_SIGNED_EN adds req_signed per requester.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int LAT       = 2,
   parameter  int RSP_DEPTH = 4,
   localparam int ID_W      = id_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
`ifdef MULT_ARB_SIGNED_EN
   input  logic [NUM_REQ-1:0]        req_signed,
`endif
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [PROD_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      busy
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    outst_q, outst_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PROD_W-1:0]   data_mem_q [RSP_DEPTH];
   logic [PROD_W-1:0]   data_mem_d [RSP_DEPTH];
   logic [ID_MAX_W-1:0] id_mem_q   [RSP_DEPTH];
   logic [ID_MAX_W-1:0] id_mem_d   [RSP_DEPTH];

   logic                win_found_s;
   logic [ID_W-1:0]     win_idx_s;
   logic [ID_W-1:0]     cand_idx_s;
   logic                hit_s;
   logic                credit_ok_s;
   logic                accept_s;
   logic                push_s;
   logic                pop_s;
   logic                fifo_nonempty_s;
   logic                pipe_busy_s;
   mult_op_t            op_s;
   logic [PROD_W-1:0]   pipe_prod_s;
   logic [ID_MAX_W-1:0] pipe_id_s;

   // Increment a FIFO pointer with wrap at RSP_DEPTH (need not be a power of two)
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Round-robin pick starting at rr_ptr, gated by the credit cap
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_idx_s  = '0;
      hit_s       = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx_s  = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         hit_s       = !win_found_s && req_valid[cand_idx_s];
         win_idx_s   = hit_s ? cand_idx_s : win_idx_s;
         win_found_s = win_found_s | hit_s;
      end
      // Credit is judged on the registered count: a same-cycle pop frees nothing
      credit_ok_s = (outst_q < CNT_W'(RSP_DEPTH));
      accept_s    = win_found_s & credit_ok_s;
      req_ready   = '0;
      req_ready[win_idx_s] = accept_s;

      op_s.a  = req_a[int'(win_idx_s)*DATA_W +: DATA_W];
      op_s.b  = req_b[int'(win_idx_s)*DATA_W +: DATA_W];
      op_s.id = ID_MAX_W'(win_idx_s);
`ifdef MULT_ARB_SIGNED_EN
      op_s.signed_flag = req_signed[win_idx_s];
`else
      op_s.signed_flag = 1'b0;
`endif

      if (accept_s) begin
         rr_ptr_d = (int'(win_idx_s) == NUM_REQ - 1) ? '0 : win_idx_s + ID_W'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   mult_pipe #(
      .LAT(LAT)
   ) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (accept_s),
      .in_op    (op_s),
      .out_valid(push_s),
      .out_prod (pipe_prod_s),
      .out_id   (pipe_id_s),
      .busy     (pipe_busy_s)
   );

   assign fifo_nonempty_s = (count_q != '0);
   assign pop_s           = fifo_nonempty_s & rsp_ready;

   // Credit counter, FIFO occupancy, pointers and storage next-state
   always_comb begin
      if (accept_s && !pop_s) begin
         outst_d = outst_q + CNT_W'(1);
      end else if (!accept_s && pop_s) begin
         outst_d = outst_q - CNT_W'(1);
      end else begin
         outst_d = outst_q;
      end

      if (push_s && !pop_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_s && pop_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end

      wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      data_mem_d = data_mem_q;
      id_mem_d   = id_mem_q;
      if (push_s) begin
         data_mem_d[wr_ptr_q] = pipe_prod_s;
         id_mem_d[wr_ptr_q]   = pipe_id_s;
      end else begin
         data_mem_d[wr_ptr_q] = data_mem_q[wr_ptr_q];
         id_mem_d[wr_ptr_q]   = id_mem_q[wr_ptr_q];
      end
   end

   // Control state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         outst_q  <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         outst_q  <= outst_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count
   always_ff @(posedge clk) begin
      data_mem_q <= data_mem_d;
      id_mem_q   <= id_mem_d;
   end

   // Head is forced to zero when empty so stale entries never show
   assign rsp_valid = fifo_nonempty_s;
   assign rsp_data  = fifo_nonempty_s ? data_mem_q[rd_ptr_q] : '0;
   assign rsp_id    = fifo_nonempty_s ? ID_W'(id_mem_q[rd_ptr_q]) : '0;
   assign busy      = pipe_busy_s | fifo_nonempty_s;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: queue-based reference model
// (in-flight list with due times, result queue, round-robin pointer),
// directed scenarios followed by randomized traffic.
module tb_mult_arbiter;

   localparam int NR    = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int IDW   = $clog2(NR);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*32-1:0]  req_a = '0;
   logic [NR*32-1:0]  req_b = '0;
   logic [NR-1:0]     req_signed = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [63:0]       rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   always #5 clk = ~clk;

   mult_arbiter #(.NUM_REQ(NR), .LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
`ifdef MULT_ARB_SIGNED_EN
      .req_signed(req_signed),
`endif
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_id   (rsp_id),
      .busy     (busy)
   );

   typedef struct {
      logic [63:0] p;
      int          id;
      int          due;
   } ent_t;

   ent_t        infl[$];
   ent_t        fq[$];
   bit          pv[NR];
   logic [31:0] pa[NR];
   logic [31:0] pb[NR];
   bit          ps[NR];
   int          rr = 0;
   int          cyc = 0;
   int          gen_prob = 0;
   bit [NR-1:0] gen_mask = '0;
   int          rdy_mode = 1;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'h0, a} * {32'h0, b};
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(4))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One clock: drive at negedge, check against model, advance model for the coming edge
   task automatic step();
      int          occ;
      int          win;
      logic [NR-1:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (!pv[i] && gen_mask[i] && ($urandom_range(99) < gen_prob)) begin
            pv[i] = 1'b1;
            pa[i] = rand_op();
            pb[i] = rand_op();
`ifdef MULT_ARB_SIGNED_EN
            ps[i] = ($urandom_range(1) == 1);
`else
            ps[i] = 1'b0;
`endif
         end
      end
      for (int i = 0; i < NR; i++) begin
         req_valid[i]        = pv[i];
         req_a[32*i +: 32]   = pa[i];
         req_b[32*i +: 32]   = pb[i];
         req_signed[i]       = ps[i];
      end
      rsp_ready = (rdy_mode == 2) ? ($urandom_range(1) == 1) : (rdy_mode == 1);
      #1;
      occ = infl.size() + fq.size();
      win = -1;
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (rr + k) % NR;
         if (win < 0 && pv[idx]) win = idx;
      end
      exp_rdy = '0;
      if (win >= 0 && occ < DEPTH) exp_rdy = NR'(1) << win;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(fq.size() > 0));
      chk("busy", 64'(busy), 64'(occ > 0));
      if (fq.size() > 0) begin
         chk("rsp_data", rsp_data, fq[0].p);
         chk("rsp_id", 64'(rsp_id), 64'(fq[0].id));
      end
      if (fq.size() > 0 && rsp_ready) void'(fq.pop_front());
      while (infl.size() > 0 && infl[0].due == cyc) fq.push_back(infl.pop_front());
      if (win >= 0 && occ < DEPTH) begin
         infl.push_back('{ref_prod(pa[win], pb[win], ps[win]), win, cyc + LAT});
         pv[win] = 1'b0;
         rr = (win + 1) % NR;
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NR; i++) pv[i] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      infl.delete();
      fq.delete();
      rr = 0;
      @(negedge clk);
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_rsp_id", 64'(rsp_id), 64'h0);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      gen_mask = '0;
      rdy_mode = 1;
      repeat (n) step();
   endtask

   // Directed single request from requester 0, product checked against a constant
   task automatic single(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [63:0] exp, input string tag);
      gen_mask = '0;
      rdy_mode = 1;
      pv[0] = 1'b1;
      pa[0] = a;
      pb[0] = b;
      ps[0] = s;
      repeat (3) step();
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 64'(rsp_valid), 64'h1);
      chk({tag, "_data"}, rsp_data, exp);
      chk({tag, "_id"}, 64'(rsp_id), 64'h0);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
         pb[i] = '0;
         ps[i] = 1'b0;
      end
      do_reset(2);

      // Basic latency: 3*5 with LAT=2
      single(32'd3, 32'd5, 1'b0, 64'd15, "t1");
      idle(6);

      // Full-scale unsigned operands
      single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "t4u");
      idle(6);
`ifdef MULT_ARB_SIGNED_EN
      single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, "t4s");
      idle(6);
`endif

      // All requesters valid continuously: round-robin from 0
      do_reset(1);
      gen_mask = '1;
      gen_prob = 100;
      rdy_mode = 1;
      repeat (24) step();
      idle(16);

      // Credit cap with consumer stalled, then release (full FIFO pop + blocked accept)
      gen_mask = 4'b0001;
      gen_prob = 100;
      rdy_mode = 0;
      repeat (10) step();
      rdy_mode = 1;
      repeat (12) step();
      idle(12);

      // Reset with two results in flight and two queued
      gen_mask = 4'b0001;
      gen_prob = 100;
      rdy_mode = 0;
      repeat (4) step();
      do_reset(1);
      gen_mask = '1;
      gen_prob = 100;
      rdy_mode = 1;
      repeat (8) step();
      idle(12);

      // Randomized traffic with random back-pressure
      gen_mask = '1;
      gen_prob = 40;
      rdy_mode = 2;
      repeat (400) step();
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
